// File: rtl/md_pad_scanner.sv
// Scans a DB9 port by toggling SELECT through eight phases so Atari, Megadrive
// 3-button and 6-button pads are all decoded and committed together once per scan.
module md_pad_scanner #(
    parameter int STEP_CYCLES = 280,
    parameter int IDLE_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] joy_raw,
    output logic       joy_select,
    output logic [5:0] db9joy_out,
    output logic [5:0] md_extra,
    output logic       pad_is_md,
    output logic       pad_is_6btn,
    output logic       scan_done,
    output logic [3:0] dbg_state
);
    localparam int CNT_MAX = (STEP_CYCLES > IDLE_CYCLES) ? STEP_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_S0 = 4'd1, ST_S1 = 4'd2, ST_S2 = 4'd3, ST_S3 = 4'd4,
        ST_S4 = 4'd5, ST_S5 = 4'd6, ST_S6 = 4'd7, ST_S7 = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_next_sel;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_commit_pend;
    logic             r_select;
    logic [5:0]       r_db9;
    logic [5:0]       r_extra;
    logic             r_is_md;
    logic             r_is_6btn;
    logic             r_scan_done;
    // Shadow captures, only visible on outputs after the commit
    logic [5:0]       r_sh_s0;
    logic             r_sh_start, r_sh_a, r_sh_x, r_sh_y, r_sh_z, r_sh_mode;
    logic             r_md_det, r_six_det;

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_S0:   w_next_state = ST_S1;
            ST_S1:   w_next_state = ST_S2;
            ST_S2:   w_next_state = ST_S3;
            ST_S3:   w_next_state = ST_S4;
            ST_S4:   w_next_state = ST_S5;
            ST_S5:   w_next_state = ST_S6;
            ST_S6:   w_next_state = ST_S7;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_next_sel = !(w_next_state inside {ST_S1, ST_S3, ST_S5, ST_S7});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_step_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_commit_pend <= 1'b0;
            r_select      <= 1'b1;
            r_db9         <= 6'h3F;
            r_extra       <= 6'h3F;
            r_is_md       <= 1'b0;
            r_is_6btn     <= 1'b0;
            r_scan_done   <= 1'b0;
            r_sh_s0       <= 6'h3F;
            r_sh_start    <= 1'b1;
            r_sh_a        <= 1'b1;
            r_sh_x        <= 1'b1;
            r_sh_y        <= 1'b1;
            r_sh_z        <= 1'b1;
            r_sh_mode     <= 1'b1;
            r_md_det      <= 1'b0;
            r_six_det     <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                // The commit takes one extra idle cycle so the scan period stays fixed
                if (r_commit_pend) begin
                    r_commit_pend <= 1'b0;
                    r_scan_done   <= 1'b1;
                    r_db9         <= r_sh_s0;
                    r_is_md       <= r_md_det;
                    r_is_6btn     <= r_md_det & r_six_det;
                    if (r_md_det)
                        r_extra <= r_six_det ?
                            {r_sh_start, r_sh_a, r_sh_x, r_sh_y, r_sh_z, r_sh_mode} :
                            {r_sh_start, r_sh_a, 4'hF};
                    else
                        r_extra <= 6'h3F;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    r_idle_cnt <= '0;
                    r_step_cnt <= '0;
                    r_state    <= ST_S0;
                    r_select   <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else if (r_step_cnt == STEP_LAST) begin
                r_step_cnt <= '0;
                case (r_state)
                    ST_S0: r_sh_s0 <= joy_raw;
                    ST_S1: begin
                        r_sh_start <= joy_raw[5];
                        r_sh_a     <= joy_raw[4];
                        r_md_det   <= ~joy_raw[1] & ~joy_raw[0];
                    end
                    ST_S5: r_six_det <= r_md_det & (joy_raw[3:0] == 4'b0000);
                    ST_S6: if (r_six_det) begin
                        r_sh_z    <= joy_raw[3];
                        r_sh_y    <= joy_raw[2];
                        r_sh_x    <= joy_raw[1];
                        r_sh_mode <= joy_raw[0];
                    end
                    default: ;
                endcase
                if (r_state == ST_S7) begin
                    r_commit_pend <= 1'b1;
                    r_idle_cnt    <= '0;
                end
                r_state  <= w_next_state;
                r_select <= w_next_sel;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign joy_select  = r_select;
    assign db9joy_out  = r_db9;
    assign md_extra    = r_extra;
    assign pad_is_md   = r_is_md;
    assign pad_is_6btn = r_is_6btn;
    assign scan_done   = r_scan_done;
    assign dbg_state   = r_state;

endmodule
